// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 block controller and its compression core.
package sha1_pkg;

    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned DIGEST_W    = 160;
    localparam int unsigned SHA1_ROUNDS = 80;

    localparam logic [DIGEST_W-1:0] SHA1_IV =
        160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

    typedef logic [BLOCK_W-1:0]  block_t;
    typedef logic [DIGEST_W-1:0] digest_t;

    typedef enum logic [1:0] {IDLE, START, RUN, OUT} state_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/sha1_block.sv
// Iterative SHA-1 compression: one round per cycle after start; the context add is combinational.
module sha1_block
    import sha1_pkg::*;
(
    input  logic    clk,
    input  logic    start_i,
    input  digest_t context_i,
    input  block_t  block_i,
    output logic    done_o,
    output digest_t context_c_o
);

    localparam int unsigned CNT_W = 7;

    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [31:0]      a_q, b_q, c_q, d_q, e_q;
    logic [31:0]      w_q [16];
    logic [31:0]      wt, f, k, tmp;

    // Round function; the 16-word window holds W[t-16..t-1] once the schedule is running
    always_comb begin
        wt = w_q[0];
        if (cnt_q >= CNT_W'(16)) wt = rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);
        f = b_q ^ c_q ^ d_q;
        k = 32'hCA62C1D6;
        if (cnt_q < CNT_W'(20)) begin
            f = (b_q & c_q) | (~b_q & d_q);
            k = 32'h5A827999;
        end else if (cnt_q < CNT_W'(40)) begin
            k = 32'h6ED9EBA1;
        end else if (cnt_q < CNT_W'(60)) begin
            f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
            k = 32'h8F1BBCDC;
        end
        tmp = rotl(a_q, 5) + f + e_q + k + wt;
    end

    // Counter free-runs and wraps, so done re-asserts every 128 cycles after a run
    always_ff @(posedge clk) begin
        if (start_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            a_q    <= context_i[159:128];
            b_q    <= context_i[127:96];
            c_q    <= context_i[95:64];
            d_q    <= context_i[63:32];
            e_q    <= context_i[31:0];
            for (int i = 0; i < 16; i++) w_q[i] <= block_i[BLOCK_W-1-32*i -: 32];
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            done_q <= (cnt_q == CNT_W'(SHA1_ROUNDS - 1));
            if (cnt_q < CNT_W'(SHA1_ROUNDS)) begin
                e_q <= d_q;
                d_q <= c_q;
                c_q <= rotl(b_q, 30);
                b_q <= a_q;
                a_q <= tmp;
                for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                w_q[15] <= wt;
            end
        end
    end

    assign done_o      = done_q;
    assign context_c_o = {a_q + context_i[159:128], b_q + context_i[127:96],
                          c_q + context_i[95:64],   d_q + context_i[63:32],
                          e_q + context_i[31:0]};

endmodule

// File: rtl/sha1_ctrl.sv
// Block sequencer around sha1_block: accepts padded blocks, chains context, emits the final digest.
module sha1_ctrl
    import sha1_pkg::*;
#(
    parameter digest_t     IV      = SHA1_IV,
    parameter int unsigned TIMEOUT = 100
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    blk_valid,
    output logic    blk_ready,
    input  block_t  blk_data,
    input  logic    blk_first,
    input  logic    blk_last,
    input  logic    abort,
    output logic    dig_valid,
    input  logic    dig_ready,
    output digest_t digest,
    output logic    busy,
    output logic    error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;

    state_e           state_q, state_d;
    digest_t          ctx_q, ctx_d, digest_q, digest_d;
    block_t           blk_q, blk_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             last_q, last_d, chain_q, chain_d, start_q, start_d;
    logic             dig_valid_q, dig_valid_d, error_q, error_d;
    logic             busy_q, busy_d, blk_ready_q, blk_ready_d;
    logic             core_done;
    digest_t          core_ctx_c;

    sha1_block u_core (
        .clk         (clk),
        .start_i     (start_q),
        .context_i   (ctx_q),
        .block_i     (blk_q),
        .done_o      (core_done),
        .context_c_o (core_ctx_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctx_q       <= IV;
            blk_q       <= '0;
            last_q      <= 1'b0;
            chain_q     <= 1'b0;
            start_q     <= 1'b0;
            tmo_q       <= '0;
            dig_valid_q <= 1'b0;
            digest_q    <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            blk_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ctx_q       <= ctx_d;
            blk_q       <= blk_d;
            last_q      <= last_d;
            chain_q     <= chain_d;
            start_q     <= start_d;
            tmo_q       <= tmo_d;
            dig_valid_q <= dig_valid_d;
            digest_q    <= digest_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            blk_ready_q <= blk_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctx_d       = ctx_q;
        blk_d       = blk_q;
        last_d      = last_q;
        chain_d     = chain_q;
        start_d     = 1'b0;
        tmo_d       = tmo_q;
        dig_valid_d = dig_valid_q;
        digest_d    = digest_q;
        error_d     = error_q;
        blk_ready_d = blk_ready_q;

        if (abort) begin
            state_d     = IDLE;
            dig_valid_d = 1'b0;
            chain_d     = 1'b0;
            ctx_d       = IV;
            error_d     = 1'b0;
            blk_ready_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (blk_valid && blk_ready_q) begin
                        blk_d  = blk_data;
                        last_d = blk_last;
                        // A continuation block with no open chain is a protocol error; restart from IV
                        if (blk_first || !chain_q) ctx_d = IV;
                        if (!blk_first && !chain_q) error_d = 1'b1;
                        chain_d     = 1'b1;
                        start_d     = 1'b1;
                        blk_ready_d = 1'b0;
                        state_d     = START;
                    end
                end
                START: begin
                    tmo_d   = '0;
                    state_d = RUN;
                end
                RUN: begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (core_done) begin
                        ctx_d = core_ctx_c;
                        if (last_q) begin
                            digest_d    = core_ctx_c;
                            dig_valid_d = 1'b1;
                            chain_d     = 1'b0;
                            state_d     = OUT;
                        end else begin
                            blk_ready_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        error_d     = 1'b1;
                        chain_d     = 1'b0;
                        ctx_d       = IV;
                        blk_ready_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                OUT: begin
                    if (dig_valid_q && dig_ready) begin
                        dig_valid_d = 1'b0;
                        blk_ready_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE) || chain_d;
    end

    // Handshakes are suppressed in the abort cycle
    assign blk_ready = blk_ready_q & ~abort;
    assign dig_valid = dig_valid_q & ~abort;
    assign digest    = digest_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule
